// File: rtl/bitfuscnn_pkg.sv
// Shared types and constants for the crossbar receive side.
package bitfuscnn_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned COORD_WIDTH = 8;

  // Precision modes; the value doubles as the row-to-entry shift amount.
  localparam logic [1:0] BW_2BIT = 2'b00;
  localparam logic [1:0] BW_4BIT = 2'b01;
  localparam logic [1:0] BW_8BIT = 2'b10;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_DRAIN,
    ACC_DONE
  } acc_state_e;

  typedef struct packed {
    logic                          valid;
    logic [COORD_WIDTH-1:0]        row;
    logic [COORD_WIDTH-1:0]        column;
    logic signed [DATA_WIDTH-1:0]  value;
  } acc_entry_t;

endpackage

// File: rtl/accumulator_bank_sat_adder.sv
// Signed two's-complement add that clamps to the representable range.
module sat_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum
);

  logic [WIDTH:0] wide;

  // The two top bits of the extended sum differ exactly on overflow.
  always_comb begin
    wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (wide[WIDTH] != wide[WIDTH-1]) begin
      sum = wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum = wide[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/accumulator_bank.sv
// One receive-side buffer bank: accumulates routed products per entry and
// drains them over a valid/ready stream on request.
module accumulator_bank
  import bitfuscnn_pkg::*;
#(
  parameter int unsigned ENTRY_COUNT = 64,
  parameter int unsigned COORD_WIDTH = bitfuscnn_pkg::COORD_WIDTH,
  parameter int unsigned DATA_WIDTH  = bitfuscnn_pkg::DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             bitwidth,
  input  logic                   wr_en,
  input  logic [COORD_WIDTH-1:0] wr_row,
  input  logic [COORD_WIDTH-1:0] wr_column,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   drain_req,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [COORD_WIDTH-1:0] out_row,
  output logic [COORD_WIDTH-1:0] out_column,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   bank_busy,
  output logic                   drain_done,
  output logic                   err_drop,
  output logic                   err_conflict
);

  localparam int unsigned IDX_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_COUNT - 1);

  acc_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [ENTRY_COUNT-1:0]  valid_q, valid_d;
  logic [COORD_WIDTH-1:0]  row_q [ENTRY_COUNT];
  logic [COORD_WIDTH-1:0]  row_d [ENTRY_COUNT];
  logic [COORD_WIDTH-1:0]  col_q [ENTRY_COUNT];
  logic [COORD_WIDTH-1:0]  col_d [ENTRY_COUNT];
  logic [DATA_WIDTH-1:0]   val_q [ENTRY_COUNT];
  logic [DATA_WIDTH-1:0]   val_d [ENTRY_COUNT];

  logic                   out_valid_q, out_valid_d;
  logic [COORD_WIDTH-1:0] out_row_q, out_row_d;
  logic [COORD_WIDTH-1:0] out_column_q, out_column_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   bank_busy_q, bank_busy_d;
  logic                   drain_done_q, drain_done_d;
  logic                   err_drop_q, err_drop_d;
  logic                   err_conflict_q, err_conflict_d;

  logic [COORD_WIDTH-1:0] wr_entry;
  logic                   wr_in_range;
  logic [IDX_W-1:0]       wr_idx;
  logic [DATA_WIDTH-1:0]  acc_sum;
  logic                   stall;

  assign wr_entry    = wr_row >> bitwidth;
  assign wr_in_range = 32'(wr_entry) < ENTRY_COUNT;
  assign wr_idx      = IDX_W'(wr_entry);
  assign stall       = out_valid_q && !out_ready;

  sat_adder #(.WIDTH(DATA_WIDTH)) u_sat_adder (
    .a   (val_q[wr_idx]),
    .b   (wr_data),
    .sum (acc_sum)
  );

  // Next-state for FSM, storage, output register and sticky errors.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    valid_d        = valid_q;
    row_d          = row_q;
    col_d          = col_q;
    val_d          = val_q;
    out_valid_d    = out_valid_q;
    out_row_d      = out_row_q;
    out_column_d   = out_column_q;
    out_data_d     = out_data_q;
    drain_done_d   = 1'b0;
    err_drop_d     = err_drop_q;
    err_conflict_d = err_conflict_q;

    case (state_q)
      ACC_IDLE: begin
        if (wr_en) begin
          if (!wr_in_range) begin
            err_drop_d = 1'b1;
          end else if (!valid_q[wr_idx]) begin
            valid_d[wr_idx] = 1'b1;
            row_d[wr_idx]   = wr_row;
            col_d[wr_idx]   = wr_column;
            val_d[wr_idx]   = wr_data;
          end else if (row_q[wr_idx] == wr_row && col_q[wr_idx] == wr_column) begin
            val_d[wr_idx] = acc_sum;
          end else begin
            err_conflict_d = 1'b1;
          end
        end
        if (drain_req) begin
          idx_d   = '0;
          state_d = ACC_DRAIN;
        end
      end

      ACC_DRAIN: begin
        if (wr_en) err_drop_d = 1'b1;
        if (!stall) begin
          if (valid_q[idx_q]) begin
            out_valid_d    = 1'b1;
            out_row_d      = row_q[idx_q];
            out_column_d   = col_q[idx_q];
            out_data_d     = val_q[idx_q];
            valid_d[idx_q] = 1'b0;
            val_d[idx_q]   = '0;
          end else begin
            out_valid_d = 1'b0;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ACC_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ACC_DONE: begin
        if (wr_en) err_drop_d = 1'b1;
        // Stay in DONE for the pulse cycle so bank_busy covers drain_done.
        if (drain_done_q) begin
          state_d = ACC_IDLE;
        end else if (!stall) begin
          out_valid_d  = 1'b0;
          drain_done_d = 1'b1;
        end
      end

      default: state_d = ACC_IDLE;
    endcase

    bank_busy_d = (state_d != ACC_IDLE);
  end

  // State and storage registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ACC_IDLE;
      idx_q          <= '0;
      valid_q        <= '0;
      for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
        val_q[i] <= '0;
      end
      out_valid_q    <= 1'b0;
      out_row_q      <= '0;
      out_column_q   <= '0;
      out_data_q     <= '0;
      bank_busy_q    <= 1'b0;
      drain_done_q   <= 1'b0;
      err_drop_q     <= 1'b0;
      err_conflict_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      valid_q        <= valid_d;
      row_q          <= row_d;
      col_q          <= col_d;
      val_q          <= val_d;
      out_valid_q    <= out_valid_d;
      out_row_q      <= out_row_d;
      out_column_q   <= out_column_d;
      out_data_q     <= out_data_d;
      bank_busy_q    <= bank_busy_d;
      drain_done_q   <= drain_done_d;
      err_drop_q     <= err_drop_d;
      err_conflict_q <= err_conflict_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_row      = out_row_q;
  assign out_column   = out_column_q;
  assign out_data     = out_data_q;
  assign bank_busy    = bank_busy_q;
  assign drain_done   = drain_done_q;
  assign err_drop     = err_drop_q;
  assign err_conflict = err_conflict_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed self-checking bench for accumulator_bank.
module tb_accumulator_bank;

  logic       clk;
  logic       reset_n;
  logic [1:0] bitwidth;
  logic       wr_en;
  logic [7:0] wr_row;
  logic [7:0] wr_column;
  logic [7:0] wr_data;
  logic       drain_req;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_row;
  logic [7:0] out_column;
  logic [7:0] out_data;
  logic       bank_busy;
  logic       drain_done;
  logic       err_drop;
  logic       err_conflict;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] beat_row[$];
  logic [7:0] beat_col[$];
  logic [7:0] beat_data[$];

  accumulator_bank #(
    .ENTRY_COUNT (64),
    .COORD_WIDTH (8),
    .DATA_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bitwidth     (bitwidth),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_column    (wr_column),
    .wr_data      (wr_data),
    .drain_req    (drain_req),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_row      (out_row),
    .out_column   (out_column),
    .out_data     (out_data),
    .bank_busy    (bank_busy),
    .drain_done   (drain_done),
    .err_drop     (err_drop),
    .err_conflict (err_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
    wr_en     = 1'b1;
    wr_row    = r;
    wr_column = c;
    wr_data   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Starts a drain and records every accepted beat until drain_done.
  task automatic run_drain(input bit toggle, output int cyc_done, output bit timed_out,
                           output int unstable, output logic busy_start);
    logic       stalled;
    logic [24:0] snap;
    beat_row.delete();
    beat_col.delete();
    beat_data.delete();
    out_ready = 1'b1;
    drain_req = 1'b1;
    @(posedge clk);
    #1;
    drain_req  = 1'b0;
    busy_start = bank_busy;
    cyc_done   = 0;
    timed_out  = 1'b1;
    unstable   = 0;
    for (int c = 1; c <= 300; c++) begin
      out_ready = toggle ? c[0] : 1'b1;
      stalled   = out_valid && !out_ready;
      snap      = {out_valid, out_row, out_column, out_data};
      if (out_valid && out_ready) begin
        beat_row.push_back(out_row);
        beat_col.push_back(out_column);
        beat_data.push_back(out_data);
      end
      @(posedge clk);
      #1;
      if (stalled && {out_valid, out_row, out_column, out_data} !== snap) unstable++;
      if (drain_done) begin
        cyc_done  = c;
        timed_out = 1'b0;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
    n_cmp++; if (out_row !== 8'h00) begin n_err++; $display("FAIL reset_out_row: got %0h expected 0", out_row); end
    n_cmp++; if (out_column !== 8'h00) begin n_err++; $display("FAIL reset_out_column: got %0h expected 0", out_column); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    n_cmp++; if (bank_busy !== 1'b0) begin n_err++; $display("FAIL reset_bank_busy: got %0h expected 0", bank_busy); end
    n_cmp++; if (drain_done !== 1'b0) begin n_err++; $display("FAIL reset_drain_done: got %0h expected 0", drain_done); end
    n_cmp++; if (err_drop !== 1'b0) begin n_err++; $display("FAIL reset_err_drop: got %0h expected 0", err_drop); end
    n_cmp++; if (err_conflict !== 1'b0) begin n_err++; $display("FAIL reset_err_conflict: got %0h expected 0", err_conflict); end
  endtask

  task automatic test_accumulate();
    int cyc; bit to; int unst; logic busy0;
    bitwidth = 2'b10;
    wr(8'd5, 8'd3, 8'h05);
    wr(8'd5, 8'd3, 8'h05);
    run_drain(1'b0, cyc, to, unst, busy0);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL acc_timeout: got %0d expected 0", to); end
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL acc_busy_start: got %0h expected 1", busy0); end
    n_cmp++; if (beat_row.size() != 1) begin n_err++; $display("FAIL acc_beats: got %0d expected 1", beat_row.size()); end
    if (beat_row.size() == 1) begin
      n_cmp++; if (beat_row[0] !== 8'd5) begin n_err++; $display("FAIL acc_row: got %0h expected 05", beat_row[0]); end
      n_cmp++; if (beat_col[0] !== 8'd3) begin n_err++; $display("FAIL acc_col: got %0h expected 03", beat_col[0]); end
      n_cmp++; if (beat_data[0] !== 8'h0A) begin n_err++; $display("FAIL acc_data: got %0h expected 0a", beat_data[0]); end
    end
    n_cmp++; if (bank_busy !== 1'b1) begin n_err++; $display("FAIL acc_busy_at_done: got %0h expected 1", bank_busy); end
    @(posedge clk); #1;
    n_cmp++; if (bank_busy !== 1'b0) begin n_err++; $display("FAIL acc_busy_after_done: got %0h expected 0", bank_busy); end
    n_cmp++; if (drain_done !== 1'b0) begin n_err++; $display("FAIL acc_done_pulse_width: got %0h expected 0", drain_done); end
  endtask

  task automatic test_saturation();
    int cyc; bit to; int unst; logic busy0;
    bitwidth = 2'b10;
    wr(8'd4, 8'd0, 8'd100);
    wr(8'd4, 8'd0, 8'd100);
    run_drain(1'b0, cyc, to, unst, busy0);
    n_cmp++; if (beat_data.size() != 1) begin n_err++; $display("FAIL sat_pos_beats: got %0d expected 1", beat_data.size()); end
    else begin
      n_cmp++; if (beat_data[0] !== 8'h7F) begin n_err++; $display("FAIL sat_pos_data: got %0h expected 7f", beat_data[0]); end
    end
    @(posedge clk); #1;
    wr(8'd4, 8'd0, 8'h9C);
    wr(8'd4, 8'd0, 8'h9C);
    run_drain(1'b0, cyc, to, unst, busy0);
    n_cmp++; if (beat_data.size() != 1) begin n_err++; $display("FAIL sat_neg_beats: got %0d expected 1", beat_data.size()); end
    else begin
      n_cmp++; if (beat_data[0] !== 8'h80) begin n_err++; $display("FAIL sat_neg_data: got %0h expected 80", beat_data[0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    int cyc; bit to; int unst; logic busy0;
    bitwidth = 2'b10;
    wr(8'd4, 8'd0, 8'd3);
    n_cmp++; if (err_conflict !== 1'b0) begin n_err++; $display("FAIL conf_before: got %0h expected 0", err_conflict); end
    wr(8'd5, 8'd1, 8'd7);
    n_cmp++; if (err_conflict !== 1'b1) begin n_err++; $display("FAIL conf_flag: got %0h expected 1", err_conflict); end
    run_drain(1'b0, cyc, to, unst, busy0);
    n_cmp++; if (beat_row.size() != 1) begin n_err++; $display("FAIL conf_beats: got %0d expected 1", beat_row.size()); end
    else begin
      n_cmp++; if ({beat_row[0], beat_col[0], beat_data[0]} !== {8'd4, 8'd0, 8'd3})
        begin n_err++; $display("FAIL conf_entry: got %0h/%0h/%0h expected 4/0/3", beat_row[0], beat_col[0], beat_data[0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc; bit to; int unst; logic busy0;
    logic [23:0] exp_beat [3];
    exp_beat[0] = {8'd0,   8'd1, 8'h11};
    exp_beat[1] = {8'd8,   8'd2, 8'h22};
    exp_beat[2] = {8'd252, 8'd3, 8'h33};
    bitwidth = 2'b10;
    wr(8'd252, 8'd3, 8'h33);
    wr(8'd0,   8'd1, 8'h11);
    wr(8'd8,   8'd2, 8'h22);
    run_drain(1'b1, cyc, to, unst, busy0);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL bp_timeout: got %0d expected 0", to); end
    n_cmp++; if (unst != 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d changes expected 0", unst); end
    n_cmp++; if (beat_row.size() != 3) begin n_err++; $display("FAIL bp_beats: got %0d expected 3", beat_row.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if ({beat_row[i], beat_col[i], beat_data[i]} !== exp_beat[i]) begin
          n_err++;
          $display("FAIL bp_beat%0d: got %0h expected %0h", i, {beat_row[i], beat_col[i], beat_data[i]}, exp_beat[i]);
        end
      end
    end
    @(posedge clk); #1;
    run_drain(1'b0, cyc, to, unst, busy0);
    n_cmp++; if (beat_row.size() != 0) begin n_err++; $display("FAIL bp_empty_beats: got %0d expected 0", beat_row.size()); end
    n_cmp++; if (cyc != 65) begin n_err++; $display("FAIL bp_empty_latency: got %0d expected 65", cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_during_drain();
    int cyc; bit to; int unst; logic busy0;
    int beats; logic [7:0] last_data; bit done_seen;
    bitwidth = 2'b10;
    n_cmp++; if (err_drop !== 1'b0) begin n_err++; $display("FAIL wdd_drop_before: got %0h expected 0", err_drop); end
    wr(8'd12, 8'd0, 8'd9);
    out_ready = 1'b1;
    drain_req = 1'b1;
    @(posedge clk); #1;
    drain_req = 1'b0;
    n_cmp++; if (bank_busy !== 1'b1) begin n_err++; $display("FAIL wdd_busy: got %0h expected 1", bank_busy); end
    wr(8'd12, 8'd0, 8'd1);
    n_cmp++; if (err_drop !== 1'b1) begin n_err++; $display("FAIL wdd_drop: got %0h expected 1", err_drop); end
    beats = 0; last_data = '0; done_seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (out_valid && out_ready) begin beats++; last_data = out_data; end
      @(posedge clk); #1;
      if (drain_done) begin done_seen = 1'b1; break; end
    end
    n_cmp++; if (done_seen !== 1'b1) begin n_err++; $display("FAIL wdd_timeout: got %0d expected 1", done_seen); end
    n_cmp++; if (beats != 1 || last_data !== 8'd9) begin n_err++; $display("FAIL wdd_storage: got %0d beats data %0h expected 1 beat data 09", beats, last_data); end
    @(posedge clk); #1;

    do_reset();
    bitwidth = 2'b00;
    n_cmp++; if (err_drop !== 1'b0) begin n_err++; $display("FAIL range_drop_cleared: got %0h expected 0", err_drop); end
    wr(8'd63, 8'd5, 8'd4);
    n_cmp++; if (err_drop !== 1'b0) begin n_err++; $display("FAIL range_edge_in: got %0h expected 0", err_drop); end
    wr(8'd255, 8'd5, 8'd4);
    n_cmp++; if (err_drop !== 1'b1) begin n_err++; $display("FAIL range_drop: got %0h expected 1", err_drop); end
    n_cmp++; if (err_conflict !== 1'b0) begin n_err++; $display("FAIL range_no_conflict: got %0h expected 0", err_conflict); end
    run_drain(1'b0, cyc, to, unst, busy0);
    n_cmp++; if (beat_row.size() != 1) begin n_err++; $display("FAIL range_beats: got %0d expected 1", beat_row.size()); end
    else begin
      n_cmp++; if ({beat_row[0], beat_data[0]} !== {8'd63, 8'd4}) begin n_err++; $display("FAIL range_entry: got %0h/%0h expected 3f/04", beat_row[0], beat_data[0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_drain();
    int cyc; bit to; int unst; logic busy0;
    int beats; int done_cnt;
    bitwidth = 2'b10;
    wr(8'd0, 8'd0, 8'd1);
    wr(8'd4, 8'd0, 8'd2);
    wr(8'd8, 8'd0, 8'd3);
    out_ready = 1'b1;
    drain_req = 1'b1;
    @(posedge clk); #1;
    drain_req = 1'b0;
    beats = 0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid && out_ready) beats++;
      @(posedge clk); #1;
      if (beats == 2) break;
    end
    n_cmp++; if (beats != 2) begin n_err++; $display("FAIL rmd_two_beats: got %0d expected 2", beats); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmd_third_pending: got %0h expected 1", out_valid); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, out_row, out_column, out_data} !== 25'd0)
      begin n_err++; $display("FAIL rmd_outputs: got %0h expected 0", {out_valid, out_row, out_column, out_data}); end
    n_cmp++; if ({bank_busy, drain_done} !== 2'b00) begin n_err++; $display("FAIL rmd_busy_done: got %0h expected 0", {bank_busy, drain_done}); end
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (drain_done) done_cnt++;
    end
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL rmd_no_done: got %0d pulses expected 0", done_cnt); end
    run_drain(1'b0, cyc, to, unst, busy0);
    n_cmp++; if (beat_row.size() != 0) begin n_err++; $display("FAIL rmd_empty_beats: got %0d expected 0", beat_row.size()); end
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rmd_timeout: got %0d expected 0", to); end
  endtask

  initial begin
    reset_n   = 1'b1;
    bitwidth  = 2'b10;
    wr_en     = 1'b0;
    wr_row    = '0;
    wr_column = '0;
    wr_data   = '0;
    drain_req = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_accumulate();
    test_saturation();
    test_conflict();
    test_backpressure();
    test_write_during_drain();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
